poly_datapath: RTL and testbench

Arithmetic datapath for the 11-coefficient Horner polynomial evaluator, directly downstream of `control`. It consumes `coeff_sel`, `sum_rst`, `sum_en` and `srdyo` from `control`, and latches the operand `xin` when `srdyi` is asserted. It evaluates y = C10·x^10 + … + C1·x + C0 one Horner step per coefficient window, using a 2-bit-per-cycle shift-add multiplier. It presents the result on `yout` when `control` signals completion.

---
 rtl/poly_pkg.sv | 51 +++++
 rtl/serial_mul2.sv | 74 +++++++
 rtl/poly_datapath.sv | 130 +++++++++++++
 tb/tb_poly_datapath.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/poly_pkg.sv
// poly_pkg: shared widths, FSM state type, Q4.12 coefficient table and
// result-formatting helpers for the Horner polynomial datapath.
// POLY_SAT_EN selects saturating (defined) or wrapping (undefined) results.
package poly_pkg;

  localparam int ACC_W  = 16;                     // accumulator / operand / coefficient width
  localparam int FRAC_W = 12;                     // Q4.12 fractional bits
  localparam int NCOEF  = 11;                     // C0..C10
  localparam int PROD_W = 2 * ACC_W;              // unsigned magnitude product width
  localparam int Q_W    = PROD_W + 1 - FRAC_W;    // signed product after realignment
  localparam int SUM_W  = Q_W + 1;                // q + C without loss

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_ADD
  } state_e;

  // Polynomial coefficients C[0..10], Q4.12 two's complement.
  localparam logic [ACC_W-1:0] COEFF [NCOEF] = '{
    16'h1000, 16'h7000, 16'h0000, 16'hF000, 16'h1000, 16'h0400,
    16'hFC00, 16'h0200, 16'h0100, 16'hFF00, 16'h0080
  };

  // Selector values past the table fall back to C0.
  function automatic logic [ACC_W-1:0] coeff_of(input logic [3:0] sel);
    if (sel < 4'(NCOEF)) return COEFF[sel];
    return COEFF[0];
  endfunction

  // Unsigned magnitude of a two's-complement value; 0x8000 maps to 32768.
  function automatic logic [ACC_W-1:0] magnitude(input logic [ACC_W-1:0] v);
    return v[ACC_W-1] ? (~v + 1'b1) : v;
  endfunction

  // Clamp a full-width sum into the signed accumulator range.
  function automatic logic [ACC_W-1:0] saturate(input logic [SUM_W-1:0] s);
    if (s[SUM_W-1:ACC_W-1] == '0 || s[SUM_W-1:ACC_W-1] == '1) return s[ACC_W-1:0];
    return s[SUM_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  endfunction

  // Accumulator write-back format: saturate or keep the low bits.
  function automatic logic [ACC_W-1:0] format_acc(input logic [SUM_W-1:0] s);
`ifdef POLY_SAT_EN
    return saturate(s);
`else
    return s[ACC_W-1:0];
`endif
  endfunction

endpackage

// File: rtl/serial_mul2.sv
// serial_mul2: unsigned ACC_W x ACC_W shift-add multiplier retiring two
// multiplier bits per cycle; eight cycles after start the product is on p
// and done is high for the last accumulation cycle.
module serial_mul2
  import poly_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ACC_W-1:0]  a,
  input  logic [ACC_W-1:0]  b,
  output logic              done,
  output logic [PROD_W-1:0] p
);

  logic [ACC_W-1:0]  mcand_q,   mcand_d;
  logic [ACC_W-1:0]  mplier_q,  mplier_d;
  logic [PROD_W-1:0] partial_q, partial_d;
  logic [2:0]        bitcnt_q,  bitcnt_d;
  logic              active_q,  active_d;
  logic [ACC_W+1:0]  pp;
  logic [PROD_W-1:0] addend;

  // Next-state: load on start, otherwise add one 2-bit partial product.
  always_comb begin
    // NOTE: every _d gets its hold value first, so no branch can leave one unassigned and infer a latch.
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    partial_d = partial_q;
    bitcnt_d  = bitcnt_q;
    active_d  = active_q;
    unique case (mplier_q[1:0])
      2'd0:    pp = '0;
      2'd1:    pp = {2'b00, mcand_q};
      2'd2:    pp = {1'b0, mcand_q, 1'b0};
      default: pp = {2'b00, mcand_q} + {1'b0, mcand_q, 1'b0};
    endcase
    addend = {{(PROD_W-ACC_W-2){1'b0}}, pp} << {bitcnt_q, 1'b0};
    if (start) begin
      mcand_d   = a;
      mplier_d  = b;
      partial_d = '0;
      bitcnt_d  = '0;
      active_d  = 1'b1;
    end else if (active_q) begin
      partial_d = partial_q + addend;
      mplier_d  = mplier_q >> 2;
      bitcnt_d  = bitcnt_q + 3'd1;
      if (bitcnt_q == 3'd7) active_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop updates from pre-edge values.
    if (rst) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      partial_q <= '0;
      bitcnt_q  <= '0;
      active_q  <= 1'b0;
    end else begin
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      partial_q <= partial_d;
      bitcnt_q  <= bitcnt_d;
      active_q  <= active_d;
    end
  end

  assign done = active_q && (bitcnt_q == 3'd7);
  assign p    = partial_q;

endmodule

// File: rtl/poly_datapath.sv
// poly_datapath: Horner-step datapath acc <= fmt((acc * x) >>> FRAC_W + C[sel]).
// Signs are handled here; the magnitude product comes from serial_mul2.
// Build option POLY_SAT_EN: saturating write-back instead of wrap-around.
module poly_datapath
  import poly_pkg::*;
(
  input  logic             clk,
  input  logic             GlobalReset,
  input  logic             srdyi,
  input  logic [ACC_W-1:0] xin,
  input  logic [3:0]       coeff_sel,
  input  logic             sum_rst,
  input  logic             sum_en,
  input  logic             srdyo,
  output logic [ACC_W-1:0] yout,
  output logic             yvld,
  output logic             busy,
  output logic             step_err
);

  state_e            state_q,    state_d;
  logic [ACC_W-1:0]  acc_q,      acc_d;
  logic [ACC_W-1:0]  x_reg_q,    x_reg_d;
  logic [3:0]        sel_prev_q, sel_prev_d;
  logic              neg_q,      neg_d;
  logic [ACC_W-1:0]  coef_q,     coef_d;
  logic [ACC_W-1:0]  yout_q,     yout_d;
  logic              yvld_q,     yvld_d;
  logic              step_err_q, step_err_d;

  logic              trig, idle, mul_start, mul_rst, mul_done;
  logic [ACC_W-1:0]  acc_mag, x_mag;
  logic [PROD_W-1:0] mul_p;
  logic [PROD_W:0]   mag_ext;
  logic [Q_W-1:0]    q;
  logic [SUM_W-1:0]  sum;

  assign idle      = (state_q == ST_IDLE);
  assign trig      = sum_en && (coeff_sel != sel_prev_q);
  assign mul_start = trig && idle && !sum_rst;
  assign mul_rst   = GlobalReset || sum_rst;
  assign acc_mag   = magnitude(acc_q);
  assign x_mag     = magnitude(x_reg_q);

  serial_mul2 u_mul (
    .clk   (clk),
    .rst   (mul_rst),
    .start (mul_start),
    .a     (acc_mag),
    .b     (x_mag),
    .done  (mul_done),
    .p     (mul_p)
  );

  // Signed realignment: floor((+/-mag) / 2^FRAC_W). For a negative product
  // the upper bits of ~mag+1 are ~mag_hi plus a carry that exists only when
  // the discarded low bits are all zero.
  always_comb begin
    mag_ext = {1'b0, mul_p};
    if (neg_q)
      q = ~mag_ext[PROD_W:FRAC_W] + Q_W'(mag_ext[FRAC_W-1:0] == '0);
    else
      q = mag_ext[PROD_W:FRAC_W];
    sum = {q[Q_W-1], q} + {{(SUM_W-ACC_W){coef_q[ACC_W-1]}}, coef_q};
  end

  // Step FSM, operand latch, result capture and error flag.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    neg_d      = neg_q;
    coef_d     = coef_q;
    step_err_d = step_err_q;
    x_reg_d    = srdyi ? xin : x_reg_q;
    sel_prev_d = coeff_sel;
    yout_d     = srdyo ? acc_q : yout_q;
    yvld_d     = srdyo;
    if (sum_rst) begin
      state_d    = ST_IDLE;
      acc_d      = '0;
      step_err_d = 1'b0;
    end else begin
      if (trig && !idle) step_err_d = 1'b1;
      unique case (state_q)
        ST_IDLE: if (trig) begin
          state_d = ST_MUL;
          neg_d   = acc_q[ACC_W-1] ^ x_reg_q[ACC_W-1];
          coef_d  = coeff_of(coeff_sel);
        end
        ST_MUL: if (mul_done) state_d = ST_ADD;
        ST_ADD: begin
          acc_d   = format_acc(sum);
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      x_reg_q    <= '0;
      sel_prev_q <= '0;
      neg_q      <= 1'b0;
      coef_q     <= '0;
      yout_q     <= '0;
      yvld_q     <= 1'b0;
      step_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      x_reg_q    <= x_reg_d;
      sel_prev_q <= sel_prev_d;
      neg_q      <= neg_d;
      coef_q     <= coef_d;
      yout_q     <= yout_d;
      yvld_q     <= yvld_d;
      step_err_q <= step_err_d;
    end
  end

  assign yout     = yout_q;
  assign yvld     = yvld_q;
  assign busy     = !idle;
  assign step_err = step_err_q;

endmodule

// File: tb/tb_poly_datapath.sv
// tb_poly_datapath: directed bench for poly_datapath. A vector table drives
// single Horner steps, hand-written sequences cover busy/abort corners, and
// an emulated control sequence runs full 11-coefficient evaluations.
module tb_poly_datapath;

`ifdef POLY_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        GlobalReset, srdyi, sum_rst, sum_en, srdyo;
  logic [15:0] xin;
  logic [3:0]  coeff_sel;
  logic [15:0] yout;
  logic        yvld, busy, step_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  poly_datapath dut (
    .clk         (clk),
    .GlobalReset (GlobalReset),
    .srdyi       (srdyi),
    .xin         (xin),
    .coeff_sel   (coeff_sel),
    .sum_rst     (sum_rst),
    .sum_en      (sum_en),
    .srdyo       (srdyo),
    .yout        (yout),
    .yvld        (yvld),
    .busy        (busy),
    .step_err    (step_err)
  );

  // Independent copy of the coefficient table for the reference model.
  localparam logic [15:0] TB_C [11] = '{
    16'h1000, 16'h7000, 16'h0000, 16'hF000, 16'h1000, 16'h0400,
    16'hFC00, 16'h0200, 16'h0100, 16'hFF00, 16'h0080
  };

  function automatic logic [15:0] model_fmt(input longint s);
    if (SAT && s > 32767)  return 16'h7FFF;
    if (SAT && s < -32768) return 16'h8000;
    return s[15:0];
  endfunction

  function automatic logic [15:0] model_horner(input logic [15:0] x);
    logic [15:0] acc;
    longint prod;
    acc = '0;
    for (int i = 10; i >= 0; i--) begin
      prod = longint'($signed(acc)) * longint'($signed(x));
      acc  = model_fmt((prod >>> 12) + longint'($signed(TB_C[i])));
    end
    return acc;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic capture(input string name, input logic [15:0] exp);
    srdyo = 1'b1;
    tick();
    srdyo = 1'b0;
    check({name, " yout"}, yout, exp);
    check({name, " yvld"}, yvld, 1);
  endtask

  task automatic clear_and_load(input logic [15:0] x);
    sum_rst = 1'b1;
    tick();
    sum_rst = 1'b0;
    xin   = x;
    srdyi = 1'b1;
    tick();
    srdyi = 1'b0;
  endtask

  task automatic step(input logic [3:0] sel, input string name);
    int lat;
    coeff_sel = sel;
    sum_en    = 1'b1;
    tick();
    wait_idle(lat);
    check({name, " latency"}, lat, 9);
  endtask

  // Emulates control: clear at cnt 0, load x at 1, steps C10..C0 every 16
  // cycles from cnt 18, result capture at 197.
  task automatic run_control(input logic [15:0] x, input logic [15:0] exp, input string name);
    for (int cnt = 0; cnt < 200; cnt++) begin
      sum_rst = (cnt == 0);
      srdyi   = (cnt == 1);
      srdyo   = (cnt == 197);
      sum_en  = (cnt >= 2);
      xin     = x;
      if (cnt == 0) coeff_sel = 4'd0;
      if (cnt >= 18 && cnt <= 178 && ((cnt - 18) % 16) == 0)
        coeff_sel = 4'(10 - (cnt - 18) / 16);
      if (cnt == 188) check({name, " idle@188"}, busy, 0);
      if (cnt == 197) check({name, " yvld@197"}, yvld, 0);
      if (cnt == 198) begin
        check({name, " yvld@198"}, yvld, 1);
        check({name, " yout"}, yout, exp);
      end
      if (cnt == 199) check({name, " yvld@199"}, yvld, 0);
      tick();
    end
  endtask

  typedef struct {
    bit          rst;
    logic [15:0] x;
    logic [3:0]  sel;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [15];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;

    vecs[0]  = '{1'b1, 16'h7000, 4'd1,  16'h7000};
    vecs[1]  = '{1'b0, 16'h7000, 4'd2,  SAT ? 16'h7FFF : 16'h1000};
    vecs[2]  = '{1'b1, 16'h2000, 4'd3,  16'hF000};
    vecs[3]  = '{1'b0, 16'h2000, 4'd2,  16'hE000};
    vecs[4]  = '{1'b0, 16'h7000, 4'd12, SAT ? 16'h8000 : 16'h3000};
    vecs[5]  = '{1'b1, 16'h8000, 4'd3,  16'hF000};
    vecs[6]  = '{1'b0, 16'h8000, 4'd4,  SAT ? 16'h7FFF : 16'h9000};
    vecs[7]  = '{1'b1, 16'h8000, 4'd5,  16'h0400};
    vecs[8]  = '{1'b0, 16'h8000, 4'd6,  16'hDC00};
    vecs[9]  = '{1'b0, 16'h0001, 4'd7,  16'h01FD};
    vecs[10] = '{1'b0, 16'hFFFF, 4'd8,  16'h00FF};
    vecs[11] = '{1'b0, 16'h1000, 4'd9,  16'hFFFF};
    vecs[12] = '{1'b0, 16'h8000, 4'd10, 16'h0088};
    vecs[13] = '{1'b0, 16'h8000, 4'd11, 16'h0BC0};
    vecs[14] = '{1'b0, 16'h1000, 4'd0,  16'h1BC0};

    GlobalReset = 1'b1;
    srdyi = 1'b0; sum_rst = 1'b0; sum_en = 1'b0; srdyo = 1'b0;
    xin = '0; coeff_sel = '0;
    repeat (3) tick();
    GlobalReset = 1'b0;
    check("reset yout", yout, 0);
    check("reset yvld", yvld, 0);
    check("reset busy", busy, 0);
    check("reset step_err", step_err, 0);

    // Single-step vectors.
    for (int i = 0; i < 15; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      if (vecs[i].rst) begin
        sum_rst = 1'b1;
        tick();
        sum_rst = 1'b0;
      end
      xin   = vecs[i].x;
      srdyi = 1'b1;
      tick();
      srdyi = 1'b0;
      step(vecs[i].sel, nm);
      capture(nm, vecs[i].exp);
    end

    // Trigger while busy: flagged, ignored; then sum_rst clears.
    clear_and_load(16'h1000);
    coeff_sel = 4'd1;
    sum_en    = 1'b1;
    tick();
    repeat (4) tick();
    coeff_sel = 4'd2;
    tick();
    check("busy trig step_err", step_err, 1);
    check("busy trig busy", busy, 1);
    wait_idle(lat);
    check("busy trig remaining", lat, 4);
    capture("busy trig first step", 16'h7000);
    check("step_err sticky", step_err, 1);
    sum_rst = 1'b1;
    tick();
    sum_rst = 1'b0;
    check("sum_rst step_err", step_err, 0);
    check("sum_rst busy", busy, 0);
    capture("sum_rst acc", 16'h0000);

    // sum_rst aborts a step; sum_rst beats a same-cycle trigger.
    coeff_sel = 4'd3;
    tick();
    repeat (3) tick();
    check("abort pre busy", busy, 1);
    sum_rst = 1'b1;
    tick();
    sum_rst = 1'b0;
    check("abort busy", busy, 0);
    repeat (12) tick();
    capture("abort acc", 16'h0000);
    sum_rst   = 1'b1;
    coeff_sel = 4'd4;
    tick();
    sum_rst = 1'b0;
    check("rst priority busy", busy, 0);
    repeat (12) tick();
    capture("rst priority acc", 16'h0000);

    // srdyo in the ADD cycle captures the pre-write accumulator.
    clear_and_load(16'h1000);
    step(4'd1, "prewrite setup");
    coeff_sel = 4'd3;
    tick();
    repeat (8) tick();
    check("prewrite in ADD", busy, 1);
    srdyo = 1'b1;
    tick();
    srdyo = 1'b0;
    check("prewrite yout", yout, 16'h7000);
    check("prewrite busy", busy, 0);
    capture("postwrite", 16'h6000);

    // x reload mid-step: in-flight step keeps old x, next step uses new x.
    clear_and_load(16'h1000);
    step(4'd1, "xreload setup");
    coeff_sel = 4'd2;
    tick();
    repeat (2) tick();
    xin   = 16'h2000;
    srdyi = 1'b1;
    tick();
    srdyi = 1'b0;
    wait_idle(lat);
    capture("xreload inflight", 16'h7000);
    step(4'd3, "xreload next");
    capture("xreload next", SAT ? 16'h7FFF : 16'hD000);

    // GlobalReset mid-step.
    coeff_sel = 4'd4;
    tick();
    repeat (3) tick();
    GlobalReset = 1'b1;
    tick();
    GlobalReset = 1'b0;
    check("greset busy", busy, 0);
    check("greset yout", yout, 0);
    check("greset yvld", yvld, 0);
    check("greset step_err", step_err, 0);

    // Full evaluations with emulated control.
    run_control(16'h0000, 16'h1000, "run x=0");
    run_control(16'h1000, SAT ? 16'h7FFF : 16'h8280, "run x=1.0");
    run_control(16'h0800, model_horner(16'h0800), "run x=0.5");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
